// File: rtl/pipe_ctrl_sb.sv
// Pipeline stall/flush controller with an in-order load scoreboard.
// Tracks outstanding loads for RAW hazards and kills responses belonging to flushed loads.
module pipe_ctrl_sb #(
    parameter int STAGES   = 6,
    parameter int ID_STG   = 2,
    parameter int MEM_STG  = 4,
    parameter int LD_DEPTH = 2,
    parameter int CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [STAGES-1:0]             ext_hold,
    input  logic                          rs_ren,
    input  logic                          rt_ren,
    input  logic [4:0]                    rs,
    input  logic [4:0]                    rt,
    input  logic                          data_req,
    input  logic                          data_load,
    input  logic [4:0]                    data_wreg,
    input  logic                          data_addr_ok,
    input  logic                          data_data_ok,
    input  logic                          redirect,
    input  logic [$clog2(STAGES)-1:0]     redirect_stg,
    input  logic                          exc,
    output logic [STAGES-1:0]             stall,
    output logic [STAGES-1:0]             refresh,
    output logic                          pc_stall,
    output logic                          ld_drop,
    output logic [$clog2(LD_DEPTH+1)-1:0] sb_count,
    output logic [1:0]                    state,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic                          sb_err
);

    localparam int SW = $clog2(STAGES);
    localparam int CW = $clog2(LD_DEPTH+1);
    localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam logic [PW-1:0] LAST  = PW'(LD_DEPTH-1);
    localparam logic [CW-1:0] DEPTH = CW'(LD_DEPTH);

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, REDIR = 2'd2} state_t;

    state_t                    st;
    logic [SW-1:0]             redir_k;
    logic [LD_DEPTH-1:0]       sb_v, sb_k;
    logic [LD_DEPTH-1:0][4:0]  sb_w;
    logic [PW-1:0]             head, tail;

    logic                      pop, push, sb_full, hazard, k_held;
    logic [CW-1:0]             count_next;
    logic [STAGES-1:0]         hold, raw_stall, bubble, flush;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Stages 1..k-1; stage 0 (PC) is never refreshed.
    function automatic logic [STAGES-1:0] below(input int k);
        logic [STAGES-1:0] m;
        m = '0;
        for (int j = 1; j < STAGES; j++) m[j] = (j < k);
        return m;
    endfunction

    // A pop frees the head slot in the same cycle, so a full FIFO can still accept a push.
    assign pop        = data_data_ok && (sb_count != '0);
    assign sb_full    = (sb_count == DEPTH) && !pop;
    assign push       = data_req && data_load && data_addr_ok && !sb_full && (st != DRAIN);
    assign count_next = sb_count + CW'(push) - CW'(pop);

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LD_DEPTH; i++)
            if (sb_v[i] && !sb_k[i] && sb_w[i] != 5'd0 &&
                ((rs_ren && rs == sb_w[i]) || (rt_ren && rt == sb_w[i])))
                hazard = 1'b1;
    end

    always_comb begin
        hold          = ext_hold;
        hold[ID_STG]  = hold[ID_STG] | hazard;
        hold[MEM_STG] = hold[MEM_STG] | (data_req && (!data_addr_ok || (data_load && sb_full)));
    end

    always_comb begin
        raw_stall = hold;
        for (int s = STAGES-2; s >= 0; s--) raw_stall[s] = raw_stall[s] | raw_stall[s+1];
    end

    always_comb begin
        bubble = '0;
        for (int s = 0; s < STAGES-1; s++) bubble[s+1] = raw_stall[s] & ~raw_stall[s+1];
    end

    always_comb begin
        flush = '0;
        if (exc)
            flush = below(STAGES);
        else if (st == DRAIN)
            flush = below(STAGES-1);
        else begin
            if (redirect)    flush = below(int'(redirect_stg));
            if (st == REDIR) flush = flush | below(int'(redir_k));
        end
    end

    assign k_held   = (int'(redirect_stg) < STAGES) && raw_stall[redirect_stg];

    assign refresh  = reset ? '0 : (bubble | flush);
    assign stall    = reset ? '0 : (raw_stall & ~(bubble | flush));
    assign pc_stall = !reset && (stall[0] || st == DRAIN);
    assign ld_drop  = !reset && pop && sb_k[head];
    assign state    = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_v     <= '0;
            sb_k     <= '0;
            sb_w     <= '0;
            head     <= '0;
            tail     <= '0;
            sb_count <= '0;
            sb_err   <= 1'b0;
        end else begin
            if (exc) sb_k <= '1;
            if (pop) begin
                sb_v[head] <= 1'b0;
                head       <= nxt(head);
            end
            // A load accepted alongside an exception still gets a response, so track it pre-killed.
            if (push) begin
                sb_v[tail] <= 1'b1;
                sb_w[tail] <= data_wreg;
                sb_k[tail] <= exc;
                tail       <= nxt(tail);
            end
            sb_count <= count_next;
            if (data_data_ok && sb_count == '0) sb_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= RUN;
            redir_k   <= '0;
            stall_cnt <= '0;
        end else begin
            if (st == RUN && stall[ID_STG] && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (exc)
                st <= (count_next != '0) ? DRAIN : RUN;
            else begin
                case (st)
                    DRAIN: if (sb_count == '0) st <= RUN;
                    default: begin
                        if (redirect) begin
                            if (k_held) begin
                                st      <= REDIR;
                                redir_k <= redirect_stg;
                            end else
                                st <= RUN;
                        end else if (st == REDIR && !raw_stall[redir_k])
                            st <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_sb.sv
// Directed bench for pipe_ctrl_sb: hazards, full scoreboard, redirect, exception drain, reset.
module tb_pipe_ctrl_sb;

    logic        clk, reset;
    logic [5:0]  ext_hold;
    logic        rs_ren, rt_ren;
    logic [4:0]  rs, rt;
    logic        data_req, data_load;
    logic [4:0]  data_wreg;
    logic        data_addr_ok, data_data_ok;
    logic        redirect;
    logic [2:0]  redirect_stg;
    logic        exc;
    logic [5:0]  stall, refresh;
    logic        pc_stall, ld_drop;
    logic [1:0]  sb_count;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic        sb_err;

    int checks = 0;
    int errors = 0;

    pipe_ctrl_sb dut (
        .clk(clk), .reset(reset), .ext_hold(ext_hold),
        .rs_ren(rs_ren), .rt_ren(rt_ren), .rs(rs), .rt(rt),
        .data_req(data_req), .data_load(data_load), .data_wreg(data_wreg),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .redirect(redirect), .redirect_stg(redirect_stg), .exc(exc),
        .stall(stall), .refresh(refresh), .pc_stall(pc_stall), .ld_drop(ld_drop),
        .sb_count(sb_count), .state(state), .stall_cnt(stall_cnt), .sb_err(sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ext_hold = '0; rs_ren = 0; rt_ren = 0; rs = '0; rt = '0;
        data_req = 0; data_load = 0; data_wreg = '0; data_addr_ok = 0; data_data_ok = 0;
        redirect = 0; redirect_stg = '0; exc = 0;
    endtask

    task automatic load(input logic [4:0] r);
        idle;
        data_req = 1; data_load = 1; data_wreg = r; data_addr_ok = 1;
    endtask

    task automatic test_reset;
        reset = 1; idle;
        ext_hold = 6'b111111; data_data_ok = 1;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (stall !== 6'b0) begin errors++; $display("FAIL reset_stall: got %b want %b", stall, 6'b0); end
        checks++; if (refresh !== 6'b0) begin errors++; $display("FAIL reset_refresh: got %b want %b", refresh, 6'b0); end
        checks++; if ({pc_stall, ld_drop} !== 2'b00) begin errors++; $display("FAIL reset_pc_ld: got %b want 00", {pc_stall, ld_drop}); end
        checks++; if ({state, sb_count, sb_err} !== 5'b0) begin errors++; $display("FAIL reset_regs: got %b want 00000", {state, sb_count, sb_err}); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        idle;
        cyc; reset = 0;
        cyc;
    endtask

    task automatic test_raw;
        cyc; load(5'd5); #1;
        checks++; if (stall !== 6'b0) begin errors++; $display("FAIL raw_push_stall: got %b want %b", stall, 6'b0); end
        cyc; idle; rs_ren = 1; rs = 5'd5; #1;
        checks++; if (sb_count !== 2'd1) begin errors++; $display("FAIL raw_count: got %0d want 1", sb_count); end
        checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL raw_stall1: got %b want %b", stall, 6'b000111); end
        checks++; if (refresh !== 6'b001000) begin errors++; $display("FAIL raw_refresh: got %b want %b", refresh, 6'b001000); end
        checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL raw_pc_stall: got %b want 1", pc_stall); end
        cyc; #1;
        checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL raw_stall2: got %b want %b", stall, 6'b000111); end
        cyc; data_data_ok = 1; #1;
        checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL raw_stall_resp: got %b want %b", stall, 6'b000111); end
        checks++; if (ld_drop !== 1'b0) begin errors++; $display("FAIL raw_ld_drop: got %b want 0", ld_drop); end
        cyc; data_data_ok = 0; #1;
        checks++; if ({stall, refresh} !== 12'b0) begin errors++; $display("FAIL raw_release: got %b want 0", {stall, refresh}); end
        checks++; if (sb_count !== 2'd0) begin errors++; $display("FAIL raw_count_end: got %0d want 0", sb_count); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL raw_stall_cnt: got %0d want 3", stall_cnt); end
        cyc; idle;
    endtask

    task automatic test_full;
        cyc; load(5'd7);
        cyc; load(5'd8);
        cyc; load(5'd9); #1;
        checks++; if (sb_count !== 2'd2) begin errors++; $display("FAIL full_count: got %0d want 2", sb_count); end
        checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL full_stall: got %b want %b", stall, 6'b011111); end
        checks++; if (refresh !== 6'b100000) begin errors++; $display("FAIL full_refresh: got %b want %b", refresh, 6'b100000); end
        cyc; data_data_ok = 1; #1;
        checks++; if (sb_count !== 2'd2) begin errors++; $display("FAIL full_no_push: got %0d want 2", sb_count); end
        checks++; if (stall !== 6'b0) begin errors++; $display("FAIL full_pop_push_stall: got %b want %b", stall, 6'b0); end
        cyc; idle; rt_ren = 1; rt = 5'd9; #1;
        checks++; if (sb_count !== 2'd2) begin errors++; $display("FAIL full_pop_push_count: got %0d want 2", sb_count); end
        checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL full_rt_hazard: got %b want %b", stall, 6'b000111); end
        cyc; idle; data_data_ok = 1;
        cyc; data_data_ok = 1;
        cyc; idle; #1;
        checks++; if (sb_count !== 2'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", sb_count); end
    endtask

    task automatic test_redirect;
        cyc; idle; redirect = 1; redirect_stg = 3'd3; #1;
        checks++; if ({refresh, stall} !== {6'b000110, 6'b0}) begin errors++; $display("FAIL redir_free: got %b want %b", {refresh, stall}, {6'b000110, 6'b0}); end
        cyc; ext_hold = 6'b010000; #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL redir_free_state: got %0d want 0", state); end
        checks++; if (refresh !== 6'b100110) begin errors++; $display("FAIL redir_enter_refresh: got %b want %b", refresh, 6'b100110); end
        checks++; if (stall !== 6'b011001) begin errors++; $display("FAIL redir_enter_stall: got %b want %b", stall, 6'b011001); end
        cyc; redirect = 0; #1;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL redir_state1: got %0d want 2", state); end
        checks++; if (refresh !== 6'b100110) begin errors++; $display("FAIL redir_refresh1: got %b want %b", refresh, 6'b100110); end
        cyc; #1;
        checks++; if ({state, stall} !== {2'd2, 6'b011001}) begin errors++; $display("FAIL redir_held2: got %b want %b", {state, stall}, {2'd2, 6'b011001}); end
        cyc; ext_hold = '0; #1;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL redir_exit_cycle_state: got %0d want 2", state); end
        checks++; if ({refresh, stall} !== {6'b000110, 6'b0}) begin errors++; $display("FAIL redir_exit_cycle: got %b want %b", {refresh, stall}, {6'b000110, 6'b0}); end
        cyc; #1;
        checks++; if ({state, refresh} !== 8'b0) begin errors++; $display("FAIL redir_back_run: got %b want 0", {state, refresh}); end
    endtask

    task automatic test_exc;
        cyc; load(5'd10);
        cyc; load(5'd11);
        cyc; idle; exc = 1; #1;
        checks++; if (refresh !== 6'b111110) begin errors++; $display("FAIL exc_refresh: got %b want %b", refresh, 6'b111110); end
        cyc; idle; data_data_ok = 1; rs_ren = 1; rs = 5'd10; #1;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL exc_drain_state: got %0d want 1", state); end
        checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL exc_pc_stall: got %b want 1", pc_stall); end
        checks++; if (refresh !== 6'b011110) begin errors++; $display("FAIL drain_refresh: got %b want %b", refresh, 6'b011110); end
        checks++; if (stall !== 6'b0) begin errors++; $display("FAIL drain_killed_hazard: got %b want %b", stall, 6'b0); end
        checks++; if (ld_drop !== 1'b1) begin errors++; $display("FAIL drain_drop1: got %b want 1", ld_drop); end
        cyc; idle; data_data_ok = 1; #1;
        checks++; if ({state, ld_drop} !== {2'd1, 1'b1}) begin errors++; $display("FAIL drain_drop2: got %b want %b", {state, ld_drop}, {2'd1, 1'b1}); end
        cyc; idle; #1;
        checks++; if ({state, sb_count, pc_stall} !== {2'd1, 2'd0, 1'b1}) begin errors++; $display("FAIL drain_zero: got %b want %b", {state, sb_count, pc_stall}, {2'd1, 2'd0, 1'b1}); end
        cyc; #1;
        checks++; if ({state, pc_stall, refresh} !== 9'b0) begin errors++; $display("FAIL drain_exit: got %b want 0", {state, pc_stall, refresh}); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL drain_sb_err: got %b want 0", sb_err); end
    endtask

    task automatic test_r0;
        cyc; load(5'd0);
        cyc; idle; rs_ren = 1; rt_ren = 1; #1;
        checks++; if ({sb_count, stall} !== {2'd1, 6'b0}) begin errors++; $display("FAIL r0_no_stall: got %b want %b", {sb_count, stall}, {2'd1, 6'b0}); end
        cyc; idle; data_data_ok = 1;
        cyc; idle; #1;
        checks++; if (sb_count !== 2'd0) begin errors++; $display("FAIL r0_pop: got %0d want 0", sb_count); end
    endtask

    task automatic test_reset_drain;
        cyc; load(5'd12);
        cyc; load(5'd13);
        cyc; idle; exc = 1;
        cyc; idle; #1;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL rstdrain_pre: got %0d want 1", state); end
        reset = 1; #1;
        checks++; if ({state, sb_count} !== 4'b0) begin errors++; $display("FAIL rstdrain_regs: got %b want 0", {state, sb_count}); end
        checks++; if ({pc_stall, refresh, stall} !== 13'b0) begin errors++; $display("FAIL rstdrain_outs: got %b want 0", {pc_stall, refresh, stall}); end
        cyc; reset = 0; data_data_ok = 1; #1;
        checks++; if (ld_drop !== 1'b0) begin errors++; $display("FAIL rstdrain_ld_drop: got %b want 0", ld_drop); end
        cyc; data_data_ok = 0; #1;
        checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL rstdrain_sb_err: got %b want 1", sb_err); end
    endtask

    initial begin
        test_reset;
        test_raw;
        test_full;
        test_redirect;
        test_exc;
        test_r0;
        test_reset_drain;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
